// File: rtl/hist_pkg.sv
// Shared types and helpers for the per-frame luminance histogram.
package hist_pkg;

  localparam int unsigned DEF_COLORDEPTH = 8;
  localparam int unsigned DEF_BIN_BITS   = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 32;
  localparam int unsigned NUM_BINS       = 1 << DEF_BIN_BITS;

  typedef enum logic [2:0] {
    CLEAR_ALL,
    WAIT_VS,
    ACCUM,
    DRAIN,
    SWAP,
    CLEAR
  } hist_state_t;

  // Bin count for a given bin index width.
  function automatic int unsigned num_bins(input int unsigned bin_bits);
    return 1 << bin_bits;
  endfunction

  // Bin index is the top bin_bits bits of the pixel.
  function automatic logic [15:0] bin_of(input logic [31:0] pix,
                                         input int unsigned colordepth,
                                         input int unsigned bin_bits);
    return 16'(pix >> (colordepth - bin_bits));
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a toggle-encoded strobe; emits a one-cycle
// registered pulse for every level change seen on the synchronised input.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      det   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= tgl;
      sync2 <= sync1;
      det   <= sync2;
      pulse <= sync2 ^ det;
    end
  end

endmodule

// File: rtl/frame_histogram.sv
// Per-frame luminance histogram with ping-pong bin banks, saturating
// counters, RMW forwarding and a toggle strobe/ack readout port.
module frame_histogram
  import hist_pkg::*;
#(
  parameter int unsigned COLORDEPTH = 8,
  parameter int unsigned BIN_BITS   = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter bit          POL_VS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  input  logic                  rd_strobe_i,
  input  logic [BIN_BITS-1:0]   rd_addr_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [15:0]           rd_frame_o,
  output logic                  rd_ack_o,
  output logic                  frame_valid_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  overflow_o
);

  localparam int unsigned BANK_DEPTH = num_bins(BIN_BITS);

  hist_state_t state;
  hist_state_t state_nxt;

  logic                 acc_sel;
  logic [BIN_BITS-1:0]  clr_addr;
  logic                 clr_last;
  logic                 drain_cnt;
  logic                 vs_act;
  logic                 vs_r;
  logic                 vs_rr;
  logic                 frame_edge;

  logic                 clr_we;
  logic                 clr_both;
  logic                 accum;
  logic                 swap;
  logic                 drop;

  logic                 s0_dv;
  logic [BIN_BITS-1:0]  s0_bin;
  logic                 s1_dv;
  logic [BIN_BITS-1:0]  s1_bin;
  logic [CNT_WIDTH-1:0] s1_val;
  logic [CNT_WIDTH-1:0] acc_rd;
  logic [CNT_WIDTH-1:0] wr_val;
  logic                 sat_hit;
  logic                 fwd;
  logic                 rd_req;

  logic [CNT_WIDTH-1:0] bank0 [BANK_DEPTH];
  logic [CNT_WIDTH-1:0] bank1 [BANK_DEPTH];

  assign vs_act     = POL_VS ? vs_i : ~vs_i;
  assign frame_edge = vs_r & ~vs_rr;
  assign clr_last   = (clr_addr == BIN_BITS'(BANK_DEPTH - 1));

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    clr_both  = 1'b0;
    accum     = 1'b0;
    swap      = 1'b0;
    drop      = 1'b0;
    case (state)
      CLEAR_ALL: begin
        clr_we   = 1'b1;
        clr_both = 1'b1;
        if (clr_last) state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (frame_edge) state_nxt = ACCUM;
      end
      ACCUM: begin
        accum = 1'b1;
        if (frame_edge) state_nxt = DRAIN;
      end
      DRAIN: begin
        drop = dv_i;
        if (drain_cnt) state_nxt = SWAP;
      end
      SWAP: begin
        swap      = 1'b1;
        drop      = dv_i;
        state_nxt = CLEAR;
      end
      CLEAR: begin
        clr_we = 1'b1;
        drop   = dv_i;
        if (clr_last) state_nxt = ACCUM;
      end
      default: state_nxt = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR_ALL;
    else     state <= state_nxt;
  end

  // Frame bookkeeping, clear sweep address and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r          <= 1'b0;
      vs_rr         <= 1'b0;
      clr_addr      <= '0;
      drain_cnt     <= 1'b0;
      acc_sel       <= 1'b0;
      frame_cnt_o   <= '0;
      frame_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      vs_r      <= vs_act;
      vs_rr     <= vs_r;
      clr_addr  <= clr_we ? clr_addr + BIN_BITS'(1) : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (swap) begin
        acc_sel       <= ~acc_sel;
        frame_cnt_o   <= frame_cnt_o + 16'd1;
        frame_valid_o <= 1'b1;
      end
      if (drop || sat_hit) overflow_o <= 1'b1;
    end
  end

  // S1 forwards the S2 result when both stages hit the same bin.
  assign acc_rd  = acc_sel ? bank1[s0_bin] : bank0[s0_bin];
  assign sat_hit = s1_dv && (&s1_val);
  assign wr_val  = (&s1_val) ? s1_val : s1_val + CNT_WIDTH'(1);
  assign fwd     = s0_dv && s1_dv && (s0_bin == s1_bin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_dv  <= 1'b0;
      s0_bin <= '0;
      s1_dv  <= 1'b0;
      s1_bin <= '0;
      s1_val <= '0;
    end else begin
      s0_dv  <= accum && dv_i;
      s0_bin <= BIN_BITS'(bin_of(32'(pix_i), COLORDEPTH, BIN_BITS));
      s1_dv  <= s0_dv;
      s1_bin <= s0_bin;
      s1_val <= fwd ? wr_val : acc_rd;
    end
  end

  // Bin banks: clear sweep has priority; pipeline is empty while clearing.
  always_ff @(posedge clk) begin
    if (clr_we && (clr_both || !acc_sel)) bank0[clr_addr] <= '0;
    else if (s1_dv && !acc_sel)           bank0[s1_bin]   <= wr_val;
    if (clr_we && (clr_both || acc_sel))  bank1[clr_addr] <= '0;
    else if (s1_dv && acc_sel)            bank1[s1_bin]   <= wr_val;
  end

  toggle_sync u_rd_sync (
    .clk   (clk),
    .rst   (rst),
    .tgl   (rd_strobe_i),
    .pulse (rd_req)
  );

  // Readout uses the pre-swap bank and count when a request meets SWAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o  <= '0;
      rd_frame_o <= '0;
      rd_ack_o   <= 1'b0;
    end else if (rd_req) begin
      rd_data_o  <= acc_sel ? bank0[rd_addr_i] : bank1[rd_addr_i];
      rd_frame_o <= frame_cnt_o;
      rd_ack_o   <= ~rd_ack_o;
    end
  end

endmodule
